// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared types and encodings for the pipeline flush / redirect controller.
// The state encodings are exported so debug/trace logic can decode controller state.
package flush_redirect_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] FRC_IDLE     = 2'd0;
  localparam logic [1:0] FRC_DRAIN    = 2'd1;
  localparam logic [1:0] FRC_REDIRECT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = FRC_IDLE,
    ST_DRAIN    = FRC_DRAIN,
    ST_REDIRECT = FRC_REDIRECT
  } frc_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              is_ertn;
  } redirect_req_t;

  // An exception outranks an ERTN retiring in the same cycle.
  function automatic redirect_req_t pick_redirect(input logic              wb_ex,
                                                  input logic [ADDR_W-1:0] eentry,
                                                  input logic [ADDR_W-1:0] era);
    redirect_req_t r;
    r.pc      = wb_ex ? eentry : era;
    r.is_ertn = ~wb_ex;
    return r;
  endfunction

endpackage

// File: rtl/flush_redirect_ctrl_if.sv
// WB/CSR/SRAM/IF-facing signal bundle of the flush/redirect controller.
// master = the controller itself, slave = the surrounding pipeline.
interface flush_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import flush_redirect_ctrl_pkg::*;

  logic              wb_ex;
  logic              ertn_flush;
  logic [ADDR_W-1:0] csr_eentry;
  logic [ADDR_W-1:0] csr_era;
  logic              data_req_hs;
  logic              data_resp;
  logic              if_redirect_ready;

  logic              flush;
  logic              flush_busy;
  logic              discard_resp;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  ex_count;
  logic [CNT_W-1:0]  ertn_count;

  modport master (
    input  wb_ex, ertn_flush, csr_eentry, csr_era,
    input  data_req_hs, data_resp, if_redirect_ready,
    output flush, flush_busy, discard_resp, redirect_valid, redirect_pc,
    output ex_count, ertn_count
  );

  modport slave (
    output wb_ex, ertn_flush, csr_eentry, csr_era,
    output data_req_hs, data_resp, if_redirect_ready,
    input  flush, flush_busy, discard_resp, redirect_valid, redirect_pc,
    input  ex_count, ertn_count
  );

endinterface

// File: rtl/flush_redirect_ctrl_outst_counter.sv
// Up/down counter of in-flight SRAM transactions with overflow/underflow detect.
// An illegal step holds the count; the flags let the owner flag the protocol error.
module flush_redirect_ctrl_outst_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next_c,
  output logic         overflow_c,
  output logic         underflow_c
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_comb begin
    overflow_c   = inc & ~dec & (count == CNT_MAX);
    underflow_c  = dec & ~inc & (count == '0);
    count_next_c = count;
    if (!overflow_c && !underflow_c) begin
      if (inc && !dec) begin
        count_next_c = count + W'(1);
      end else if (dec && !inc) begin
        count_next_c = count - W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Pipeline recovery sequencer: flushes on WB exception/ERTN, drains stale data-SRAM
// responses, then holds the redirect toward IF until it is accepted.
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int unsigned OUTST_W = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  flush_redirect_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  frc_state_e        state_q;
  frc_state_e        state_d;
  logic              trig_c;
  logic              load_c;
  logic              flush_c;
  logic              discard_c;
  redirect_req_t     req_c;

  logic [OUTST_W-1:0] outst;
  logic [OUTST_W-1:0] outst_next_c;
  logic               outst_ovf_c;
  logic               outst_udf_c;

  logic [ADDR_W-1:0] redirect_pc_q;
  logic [CNT_W-1:0]  ex_cnt_q;
  logic [CNT_W-1:0]  ertn_cnt_q;

  flush_redirect_ctrl_outst_counter #(
    .W (OUTST_W)
  ) u_outst (
    .clk          (clk),
    .rst          (rst),
    .inc          (bus.data_req_hs),
    .dec          (bus.data_resp),
    .count        (outst),
    .count_next_c (outst_next_c),
    .overflow_c   (outst_ovf_c),
    .underflow_c  (outst_udf_c)
  );

  // Gated by rst so an asserted reset silences the combinational flush at once.
  assign trig_c = (bus.wb_ex | bus.ertn_flush) & ~rst;
  assign req_c  = pick_redirect(bus.wb_ex, bus.csr_eentry, bus.csr_era);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flush_c   = 1'b0;
    discard_c = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_c) begin
          flush_c = 1'b1;
          load_c  = 1'b1;
          state_d = (outst_next_c != '0) ? ST_DRAIN : ST_REDIRECT;
        end
      end
      ST_DRAIN: begin
        discard_c = bus.data_resp;
        if (outst_next_c == '0) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        discard_c = bus.data_resp;
        if (bus.if_redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Redirect target and saturating event counters, captured on the trigger cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q <= '0;
      ex_cnt_q      <= '0;
      ertn_cnt_q    <= '0;
    end else if (load_c) begin
      redirect_pc_q <= req_c.pc;
      if (req_c.is_ertn) begin
        if (ertn_cnt_q != CNT_SAT) begin
          ertn_cnt_q <= ertn_cnt_q + CNT_W'(1);
        end
      end else if (ex_cnt_q != CNT_SAT) begin
        ex_cnt_q <= ex_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.flush          = flush_c;
  assign bus.discard_resp   = discard_c;
  assign bus.flush_busy     = (state_q != ST_IDLE);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.ex_count       = ex_cnt_q;
  assign bus.ertn_count     = ertn_cnt_q;

  a_outst_range: assert property (@(posedge clk) disable iff (rst)
    !(outst_ovf_c || outst_udf_c));

  a_no_trig_busy: assert property (@(posedge clk) disable iff (rst)
    (state_q != ST_IDLE) |-> !(bus.wb_ex || bus.ertn_flush));

  a_no_req_drain: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DRAIN) |-> !bus.data_req_hs);

  a_drain_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DRAIN) |-> (outst != '0));

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Self-checking bench for flush_redirect_ctrl: redirect targets are scoreboarded at
// trigger time and popped when IF accepts the redirect; timing is checked per cycle.
module tb_flush_redirect_ctrl;
  import flush_redirect_ctrl_pkg::*;

  localparam int unsigned OUTST_W = 2;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flush_redirect_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  flush_redirect_ctrl #(
    .OUTST_W (OUTST_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_pc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive point: 1 time unit after the rising edge, single-cycle pulses cleared.
  task automatic next_cyc();
    @(posedge clk);
    #1;
    ifc.wb_ex       = 1'b0;
    ifc.ertn_flush  = 1'b0;
    ifc.data_req_hs = 1'b0;
    ifc.data_resp   = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_flush"},   32'(ifc.flush), 0);
    check_eq({tag, "_busy"},    32'(ifc.flush_busy), 0);
    check_eq({tag, "_discard"}, 32'(ifc.discard_resp), 0);
    check_eq({tag, "_rvalid"},  32'(ifc.redirect_valid), 0);
  endtask

  // Scoreboard consumer: every accepted redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (!rst && ifc.redirect_valid && ifc.if_redirect_ready) begin
      check_eq("redir_pending", 32'(exp_pc_q.size() != 0), 1);
      if (exp_pc_q.size() != 0) begin
        check_eq("redir_pc", ifc.redirect_pc, exp_pc_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst                   = 1'b1;
    ifc.wb_ex             = 1'b0;
    ifc.ertn_flush        = 1'b0;
    ifc.csr_eentry        = '0;
    ifc.csr_era           = '0;
    ifc.data_req_hs       = 1'b0;
    ifc.data_resp         = 1'b0;
    ifc.if_redirect_ready = 1'b1;
    #2;
    check_idle_outputs("rst");
    check_eq("rst_pc",   ifc.redirect_pc, 0);
    check_eq("rst_exc",  32'(ifc.ex_count), 0);
    check_eq("rst_ertn", 32'(ifc.ertn_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle exception, nothing outstanding.
    next_cyc();
    ifc.wb_ex      = 1'b1;
    ifc.csr_eentry = 32'h1c008000;
    exp_pc_q.push_back(32'h1c008000);
    sample();
    check_eq("t1_flush_T", 32'(ifc.flush), 1);
    check_eq("t1_busy_T",  32'(ifc.flush_busy), 0);
    next_cyc();
    sample();
    check_eq("t1_flush_T1",  32'(ifc.flush), 0);
    check_eq("t1_rvalid_T1", 32'(ifc.redirect_valid), 1);
    check_eq("t1_pc_T1",     ifc.redirect_pc, 32'h1c008000);
    check_eq("t1_exc",       32'(ifc.ex_count), 1);
    next_cyc();
    sample();
    check_eq("t1_state_T2", 32'(dut.state_q), 32'(FRC_IDLE));
    check_idle_outputs("t1_T2");

    // Drain two outstanding data requests.
    next_cyc();
    ifc.data_req_hs = 1'b1;
    next_cyc();
    ifc.data_req_hs = 1'b1;
    next_cyc();
    ifc.wb_ex      = 1'b1;
    ifc.csr_eentry = 32'h1c008040;
    exp_pc_q.push_back(32'h1c008040);
    sample();
    check_eq("t2_flush_T", 32'(ifc.flush), 1);
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      if (i == 2 || i == 4) ifc.data_resp = 1'b1;
      sample();
      check_eq($sformatf("t2_busy_T%0d", i),    32'(ifc.flush_busy), 1);
      check_eq($sformatf("t2_flush_T%0d", i),   32'(ifc.flush), 0);
      check_eq($sformatf("t2_discard_T%0d", i), 32'(ifc.discard_resp), 32'(i == 2 || i == 4));
      check_eq($sformatf("t2_rvalid_T%0d", i),  32'(ifc.redirect_valid), 32'(i == 5));
      if (i < 5) check_eq($sformatf("t2_state_T%0d", i), 32'(dut.state_q), 32'(FRC_DRAIN));
    end
    next_cyc();
    sample();
    check_idle_outputs("t2_T6");
    check_eq("t2_outst", 32'(dut.outst), 0);

    // ERTN with IF backpressure for three cycles.
    ifc.if_redirect_ready = 1'b0;
    next_cyc();
    ifc.ertn_flush = 1'b1;
    ifc.csr_era    = 32'h1c000124;
    exp_pc_q.push_back(32'h1c000124);
    sample();
    check_eq("t3_flush_T", 32'(ifc.flush), 1);
    for (int i = 1; i <= 4; i++) begin
      next_cyc();
      if (i == 4) ifc.if_redirect_ready = 1'b1;
      sample();
      check_eq($sformatf("t3_rvalid_T%0d", i), 32'(ifc.redirect_valid), 1);
      check_eq($sformatf("t3_pc_T%0d", i),     ifc.redirect_pc, 32'h1c000124);
    end
    next_cyc();
    sample();
    check_idle_outputs("t3_T5");
    check_eq("t3_ertn", 32'(ifc.ertn_count), 1);
    check_eq("t3_exc",  32'(ifc.ex_count), 2);

    // Simultaneous exception and ERTN: the exception wins.
    next_cyc();
    ifc.wb_ex      = 1'b1;
    ifc.ertn_flush = 1'b1;
    ifc.csr_eentry = 32'h1c008000;
    ifc.csr_era    = 32'h1c000200;
    exp_pc_q.push_back(32'h1c008000);
    next_cyc();
    sample();
    check_eq("t4_pc",   ifc.redirect_pc, 32'h1c008000);
    check_eq("t4_exc",  32'(ifc.ex_count), 3);
    check_eq("t4_ertn", 32'(ifc.ertn_count), 1);
    next_cyc();
    ifc.data_req_hs = 1'b1;
    next_cyc();
    ifc.data_req_hs = 1'b1;
    ifc.data_resp   = 1'b1;
    sample();
    check_eq("t4_discard_idle", 32'(ifc.discard_resp), 0);
    next_cyc();
    sample();
    check_eq("t4_outst_same", 32'(dut.outst), 1);
    ifc.data_resp = 1'b1;
    next_cyc();
    sample();
    check_eq("t4_outst_zero", 32'(dut.outst), 0);

    // Asynchronous reset in the middle of a drain.
    next_cyc();
    ifc.data_req_hs = 1'b1;
    next_cyc();
    ifc.wb_ex      = 1'b1;
    ifc.csr_eentry = 32'h1c0080c0;
    next_cyc();
    sample();
    check_eq("t5_state_drain", 32'(dut.state_q), 32'(FRC_DRAIN));
    #2;
    rst = 1'b1;
    exp_pc_q.delete();
    #1;
    check_idle_outputs("t5_rst");
    check_eq("t5_rst_pc",    ifc.redirect_pc, 0);
    check_eq("t5_rst_exc",   32'(ifc.ex_count), 0);
    check_eq("t5_rst_outst", 32'(dut.outst), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    next_cyc();
    ifc.wb_ex      = 1'b1;
    ifc.csr_eentry = 32'h1c008100;
    exp_pc_q.push_back(32'h1c008100);
    sample();
    check_eq("t5_flush", 32'(ifc.flush), 1);
    next_cyc();
    sample();
    check_eq("t5_state_redir", 32'(dut.state_q), 32'(FRC_REDIRECT));
    check_eq("t5_exc", 32'(ifc.ex_count), 1);

    // Saturation: 2^CNT_W + 3 further exceptions.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      next_cyc();
      ifc.wb_ex      = 1'b1;
      ifc.csr_eentry = 32'h1c009000 + 32'(i * 4);
      exp_pc_q.push_back(32'h1c009000 + 32'(i * 4));
      next_cyc();
    end
    next_cyc();
    sample();
    check_eq("t6_exc_sat", 32'(ifc.ex_count), 32'h0000000f);
    check_eq("t6_ertn",    32'(ifc.ertn_count), 0);
    check_eq("sb_empty",   32'(exp_pc_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
Sequences pipeline recovery when the write-back stage raises an exception (wb_ex) or retires ERTN (ertn_flush).
- Issues a one-cycle flush to all stages.
- Drains outstanding data-SRAM transactions so stale responses cannot reach re-fetched instructions.
- Holds a redirect request (exception entry or ERA) toward IF until IF accepts it.
- Sits between WB/CSR and the IF/ID/EX/MEM stages.

Parameters:
OUTST_W, 2, width of outstanding data-request counter (max 2^OUTST_W-1 in flight)
CNT_W, 16, width of saturating exception/ertn event counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_ex  in  1  exception retiring in WB this cycle
ertn_flush  in  1  ERTN retiring in WB this cycle
csr_eentry  in  32  exception entry address from CSR file
csr_era  in  32  return address from CSR file
data_req_hs  in  1  data-SRAM request handshake (req & addr_ok) this cycle
data_resp  in  1  data-SRAM response (data_ok) this cycle
if_redirect_ready  in  1  IF accepts redirect this cycle
flush  out  1  one-cycle pulse: kill all non-WB stage contents
flush_busy  out  1  high while recovery is in progress; stages must not issue new data requests
discard_resp  out  1  current data_resp belongs to a flushed instruction; MEM must drop it
redirect_valid  out  1  redirect request to IF
redirect_pc  out  32  redirect target
ex_count  out  CNT_W  exceptions taken, saturating
ertn_count  out  CNT_W  ERTNs taken, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE; flush=0, flush_busy=0, discard_resp=0, redirect_valid=0, redirect_pc=0, outstanding=0, both counters=0. Reset mid-operation aborts any drain or redirect immediately.
- Outstanding counter, updated every cycle in every state:
  - Next value = outstanding + data_req_hs - data_resp.
  - Simultaneous req and resp leaves it unchanged.
  - Overflow or underflow is a protocol error: the counter holds its value and the simulation assertion fires.
- Trigger = (wb_ex | ertn_flush), sampled only in IDLE.
  - If both are high, wb_ex wins: target = csr_eentry and ex_count increments.
  - Otherwise ertn_flush: target = csr_era and ertn_count increments.
  - Triggers in DRAIN or REDIRECT are ignored. A flushed pipeline cannot produce them; an assertion checks this.
- States:
  - IDLE: all outputs low.
    - On trigger (cycle T): flush=1 combinationally in cycle T; redirect_pc latched at T+1.
    - Next state at T+1 = DRAIN if the post-update outstanding count is nonzero, else REDIRECT.
  - DRAIN: flush_busy=1, redirect_valid=0.
    - discard_resp = data_resp (combinational).
    - When outstanding reaches 0 (post-update) -> REDIRECT.
    - data_req_hs in DRAIN is a protocol error (assert).
  - REDIRECT: flush_busy=1, redirect_valid=1, redirect_pc stable.
    - When if_redirect_ready=1 -> IDLE; redirect_valid drops the next cycle.
    - Any data_resp here also asserts discard_resp (defensive).
- Latency:
  - Trigger with nothing outstanding: redirect_valid rises at T+1. With if_redirect_ready tied high, the block is back in IDLE at T+2.
  - Each outstanding transaction adds at least one cycle in DRAIN.
- Counters saturate at all-ones and never wrap.
- flush asserts only in IDLE, so it is high for exactly one cycle per accepted trigger.

Decomposition:
- Shared header: state encodings FRC_IDLE/FRC_DRAIN/FRC_REDIRECT (2-bit localparams) live in macro.h beside the ECODE constants, so the debug/trace logic can decode state.
- One natural sub-module: outst_counter, the up/down counter with OUTST_W width and overflow/underflow flags. It is reused later for the instruction-SRAM side.
- The FSM and redirect latch stay in the top module.

Test Plan:
- Idle exception: wb_ex=1 at T, outstanding=0, csr_eentry=0x1c008000, if_redirect_ready=1 -> flush=1 at T only; redirect_valid=1 and redirect_pc=0x1c008000 at T+1; IDLE at T+2; ex_count=1.
- Drain: two data_req_hs before T, wb_ex at T, data_resp at T+2 and T+4 -> state DRAIN; discard_resp=1 at T+2 and T+4; redirect_valid first high at T+5; flush_busy high T+1..T+5.
- ERTN with IF backpressure: ertn_flush=1, csr_era=0x1c000124, if_redirect_ready low for 3 cycles -> redirect_valid and redirect_pc=0x1c000124 held stable 4 cycles; ertn_count=1; return to IDLE after the ready cycle.
- Simultaneous events: wb_ex=ertn_flush=1, eentry=0x1c008000, era=0x1c000200 -> redirect_pc=0x1c008000; ex_count increments, ertn_count unchanged. Separately, req and resp in the same cycle leave outstanding unchanged.
- Reset mid-drain: rst=1 asynchronously while in DRAIN with outstanding=1 -> all outputs 0 before the next clk edge; after release, a new wb_ex is handled from IDLE with outstanding=0.
- Saturation: force 2^CNT_W+3 exceptions (CNT_W=4 build) -> ex_count stays at 0xF.
